adc_frame_tx: RTL



---
 rtl/adc_frame_pkg.sv | 33 +++
 rtl/adc_frame_tx_nibble_to_hex.sv | 16 +
 rtl/adc_frame_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC sample to ASCII hex frame sender.
// Optional "0x" frame prefix is enabled by defining ADC_FRAME_PREFIX_EN.
package adc_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

  localparam int IDX_W = 3;

`ifdef ADC_FRAME_PREFIX_EN
  localparam int PREFIX_LEN = 2;
`else
  localparam int PREFIX_LEN = 0;
`endif

  localparam logic [IDX_W-1:0] IDX_HI  = IDX_W'(PREFIX_LEN);
  localparam logic [IDX_W-1:0] IDX_LO  = IDX_W'(PREFIX_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_EOL = IDX_W'(PREFIX_LEN + 2);

  function automatic int frame_len(input bit cr, input bit lf);
    return PREFIX_LEN + 2 + int'(cr) + int'(lf);
  endfunction

endpackage

// File: rtl/adc_frame_tx_nibble_to_hex.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
// Used once per frame sender on the currently selected nibble.
module nibble_to_hex
  import adc_frame_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] hex
);

  logic [7:0] nib_w;

  assign nib_w = {4'h0, nib};
  assign hex   = (nib < 4'd10) ? (ASCII_ZERO + nib_w)
                               : (HEX_ALPHA_OFS + nib_w);

endmodule

// File: rtl/adc_frame_tx.sv
// Latches one ADC sample and streams it to the UART as an ASCII hex frame.
// Build with ADC_FRAME_PREFIX_EN to prefix each frame with "0x".
module adc_frame_tx
  import adc_frame_pkg::*;
#(
  parameter bit          FRAME_CR = 1'b1,
  parameter bit          FRAME_LF = 1'b1,
  parameter int unsigned TIMEOUT  = 200000,
  parameter int          TMR_W    = 18
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sample_valid,
  input  logic [7:0] adc_data,
  input  logic       tx_stop,
  output logic [7:0] tx_data,
  output logic       load,
  output logic       busy,
  output logic [7:0] drop_cnt,
  output logic       timeout_err
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(frame_len(FRAME_CR, FRAME_LF) - 1);
  localparam logic [TMR_W-1:0] TMO_LAST =
    TMR_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_n;
  logic [7:0]         sample_reg;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   tmr;
  logic               take;
  logic               fire;
  logic               adv;
  logic               tmo;
  logic [3:0]         nib;
  logic [7:0]         hex;
  logic [7:0]         chr;

  assign nib = (idx == IDX_HI) ? sample_reg[7:4]
                               : sample_reg[3:0];

  nibble_to_hex u_hex (
    .nib (nib),
    .hex (hex)
  );

  always_comb begin
    chr = ASCII_LF;
    unique case (1'b1)
`ifdef ADC_FRAME_PREFIX_EN
      (idx == IDX_W'(0)): chr = ASCII_ZERO;
      (idx == IDX_W'(1)): chr = ASCII_X;
`endif
      (idx == IDX_HI),
      (idx == IDX_LO):    chr = hex;
      (idx == IDX_EOL && FRAME_CR):
                          chr = ASCII_CR;
      default:            chr = ASCII_LF;
    endcase
  end

  // A tx_stop arriving while load is still high is stale.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    fire    = 1'b0;
    adv     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_valid) begin
          take    = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        fire    = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (tx_stop && !load) begin
          if (idx == LAST) begin
            state_n = IDLE;
          end else begin
            adv     = 1'b1;
            state_n = LOAD;
          end
        end else if (tmr == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      sample_reg  <= 8'h00;
      idx         <= '0;
      tmr         <= '0;
      tx_data     <= 8'h00;
      load        <= 1'b0;
      busy        <= 1'b0;
      drop_cnt    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      load  <= fire;
      if (take) begin
        sample_reg <= adc_data;
        idx        <= '0;
      end
      if (adv) begin
        idx <= idx + IDX_W'(1);
      end
      if (fire) begin
        tx_data <= chr;
        tmr     <= '0;
      end else if (state == WAIT) begin
        tmr <= tmr + TMR_W'(1);
      end
      if (tmo) begin
        timeout_err <= 1'b1;
      end
      if (sample_valid && state != IDLE
          && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
